// File: rtl/dac_pattern_sequencer_pkg.sv
// Shared constants for the DAC pattern sequencer:
// FSM encodings and DAC level widths.
package dac_pattern_sequencer_pkg;

  localparam int DAC_BITS = 2;
  localparam int RGB_W    = 3 * DAC_BITS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/dac_step_table.sv
// Step table: STEPS entries of {rgb, dwell, last},
// one write port, one combinational read port.
module dac_step_table
  import dac_pattern_sequencer_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int DWELL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(STEPS)-1:0] waddr,
  input  logic [RGB_W-1:0]         wrgb,
  input  logic [DWELL_W-1:0]       wdwell,
  input  logic                     wlast,
  input  logic [$clog2(STEPS)-1:0] raddr,
  output logic [RGB_W-1:0]         rrgb,
  output logic [DWELL_W-1:0]       rdwell,
  output logic                     rlast
);

  logic [RGB_W-1:0]   rgb_mem   [STEPS];
  logic [DWELL_W-1:0] dwell_mem [STEPS];
  logic               last_mem  [STEPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        rgb_mem[i]   <= '0;
        dwell_mem[i] <= '0;
        last_mem[i]  <= 1'b0;
      end
    end else if (we) begin
      rgb_mem[waddr]   <= wrgb;
      dwell_mem[waddr] <= wdwell;
      last_mem[waddr]  <= wlast;
    end
  end

  assign rrgb   = rgb_mem[raddr];
  assign rdwell = dwell_mem[raddr];
  assign rlast  = last_mem[raddr];

endmodule

// File: rtl/dac_pattern_sequencer.sv
// Drives the r/g/b resistor DAC through a programmable
// table of levels with per-step dwell, one-shot or looping.
module dac_pattern_sequencer
  import dac_pattern_sequencer_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int DWELL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [RGB_W-1:0]         cfg_rgb,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  input  logic                     cfg_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic [DAC_BITS-1:0]      r,
  output logic [DAC_BITS-1:0]      g,
  output logic [DAC_BITS-1:0]      b
);

  localparam int AW = $clog2(STEPS);
  localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);

  logic [0:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [RGB_W-1:0]   rgb_q;
  logic               loop_q;
  logic               cur_last;

  logic [AW-1:0]      rd_addr;
  logic [RGB_W-1:0]   rd_rgb;
  logic [DWELL_W-1:0] rd_dwell;
  logic               rd_last;
  logic               at_end;

  dac_step_table #(
    .STEPS   (STEPS),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we && !busy),
    .waddr  (cfg_addr),
    .wrgb   (cfg_rgb),
    .wdwell (cfg_dwell),
    .wlast  (cfg_last),
    .raddr  (rd_addr),
    .rrgb   (rd_rgb),
    .rdwell (rd_dwell),
    .rlast  (rd_last)
  );

  // Last flag of the current entry is held locally so the
  // single read port can always look up the next entry.
  assign at_end = cur_last || (step_idx == LAST_IDX);

  always_comb begin
    rd_addr = '0;
    if (state == ST_RUN && !at_end)
      rd_addr = step_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      cnt      <= '0;
      rgb_q    <= '0;
      loop_q   <= 1'b0;
      cur_last <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start && !stop) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            step_idx <= '0;
            cnt      <= rd_dwell;
            rgb_q    <= rd_rgb;
            cur_last <= rd_last;
            loop_q   <= loop;
          end
        end
        (state == ST_RUN): begin
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            step_idx <= '0;
            rgb_q    <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!at_end || loop_q) begin
            step_idx <= rd_addr;
            cnt      <= rd_dwell;
            rgb_q    <= rd_rgb;
            cur_last <= rd_last;
          end else begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            step_idx <= '0;
            rgb_q    <= '0;
            done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign r = rgb_q[2*DAC_BITS +: DAC_BITS];
  assign g = rgb_q[DAC_BITS +: DAC_BITS];
  assign b = rgb_q[0 +: DAC_BITS];

endmodule

// File: tb/tb_dac_pattern_sequencer.sv
// Scoreboard bench for dac_pattern_sequencer: expected
// per-cycle pin vectors are queued from a table model.
module tb_dac_pattern_sequencer;

  localparam int STEPS   = 8;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_addr = '0;
  logic [5:0]         cfg_rgb = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               cfg_last = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop = 1'b0;
  logic               busy;
  logic               done;
  logic [2:0]         step_idx;
  logic [1:0]         r;
  logic [1:0]         g;
  logic [1:0]         b;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] m_rgb   [STEPS];
  int         m_dwell [STEPS];
  bit         m_last  [STEPS];

  // {busy, done, r, g, b, step_idx}
  logic [10:0] sb [$];
  logic [10:0] exp_v;
  logic [10:0] obs_v;

  always #5 clk = ~clk;

  dac_pattern_sequencer #(
    .STEPS   (STEPS),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_rgb   (cfg_rgb),
    .cfg_dwell (cfg_dwell),
    .cfg_last  (cfg_last),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  assign obs_v = {busy, done, r, g, b, step_idx};

  task automatic model_clear();
    for (int i = 0; i < STEPS; i++) begin
      m_rgb[i] = '0;
      m_dwell[i] = 0;
      m_last[i] = 1'b0;
    end
  endtask

  task automatic write_entry(input int a, input logic [5:0] c,
                             input int d, input bit l);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_rgb = c;
    cfg_dwell = DWELL_W'(d);
    cfg_last = l;
    @(negedge clk);
    cfg_we = 1'b0;
    m_rgb[a] = c;
    m_dwell[a] = d;
    m_last[a] = l;
  endtask

  task automatic load_basic();
    write_entry(0, 6'h3F, 2, 1'b0);
    write_entry(1, 6'h15, 0, 1'b0);
    write_entry(2, 6'h2A, 1, 1'b1);
  endtask

  // Independent walk of the table model, one vector per clk.
  task automatic model_push(input bit lp, input int periods);
    int i;
    for (int p = 0; p < periods; p++) begin
      i = 0;
      forever begin
        for (int k = 0; k <= m_dwell[i]; k++)
          sb.push_back({1'b1, 1'b0, m_rgb[i], 3'(i)});
        if (m_last[i] || i == STEPS - 1) break;
        i++;
      end
    end
    if (!lp) begin
      sb.push_back({1'b0, 1'b1, 6'h00, 3'd0});
      sb.push_back({1'b0, 1'b0, 6'h00, 3'd0});
    end
  endtask

  task automatic kick(input bit lp);
    @(negedge clk);
    start = 1'b1;
    loop = lp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_v !== 11'h0) begin
      n_err++;
      $display("FAIL reset_init got=%h exp=%h", obs_v, 11'h0);
    end
    rst_n = 1'b1;
    model_clear();
    load_basic();
    kick(1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== 11'h0) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", obs_v, 11'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    model_push(1'b0, 1);
    kick(1'b0);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_table cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_one_shot();
    int cyc;
    load_basic();
    model_push(1'b0, 1);
    kick(1'b0);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL one_shot cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_loop();
    int cyc;
    model_push(1'b1, 3);
    sb.push_back({1'b0, 1'b0, 6'h00, 3'd0});
    kick(1'b1);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL loop cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      cyc++;
      stop = (sb.size() == 1);
      @(negedge clk);
    end
    stop = 1'b0;
    loop = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    for (int i = 0; i < STEPS; i++)
      write_entry(i, 6'(i * 9 + 1), 0, 1'b0);
    model_push(1'b0, 1);
    kick(1'b0);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    int cyc;
    load_basic();
    write_entry(3, 6'h00, 0, 1'b0);
    repeat (3) sb.push_back({1'b1, 1'b0, 6'h3F, 3'd0});
    sb.push_back({1'b1, 1'b0, 6'h15, 3'd1});
    sb.push_back({1'b0, 1'b0, 6'h00, 3'd0});
    sb.push_back({1'b0, 1'b0, 6'h00, 3'd0});
    sb.push_back({1'b0, 1'b0, 6'h00, 3'd0});
    kick(1'b0);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      stop = (cyc == 3) || (cyc >= 4);
      start = (cyc >= 4);
      cyc++;
      @(negedge clk);
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_illegal();
    int cyc;
    model_push(1'b0, 1);
    model_push(1'b0, 1);
    kick(1'b0);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      cfg_we = (cyc == 1);
      cfg_addr = 3'd0;
      cfg_rgb = 6'h01;
      cfg_dwell = DWELL_W'(5);
      cfg_last = 1'b1;
      start = (cyc == 1) || (cyc == 7);
      cyc++;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_stop();
    test_illegal();
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
